// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared control type and elaboration checks for the pipelined mux tree
package mux_pkg;

   // Widest select the control struct can carry (up to 65536 channels).
   localparam int SEL_MAX = 16;

   typedef struct packed {
      logic               valid;
      logic [SEL_MAX-1:0] sel;
   } stage_ctrl_t;

   function automatic bit is_pow2(input int unsigned v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// rtl/mux_tree_stage.sv - one registered level of the mux tree: a row of mux2 plus its pipeline register
module mux_tree_stage
   import mux_pkg::*;
#(
   parameter int N       = 32,
   parameter int IN_W    = 8,
   parameter int SEL_BIT = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  adv,
   input  stage_ctrl_t           ctrl_in,
   input  logic [IN_W*N-1:0]     data_in,
   output stage_ctrl_t           ctrl_out,
   output logic [(IN_W/2)*N-1:0] data_out
);

   localparam int OUT_W = IN_W / 2;
   // Only the select bits below the one consumed here travel onward.
   localparam logic [SEL_MAX-1:0] SEL_KEEP = SEL_MAX'((1 << SEL_BIT) - 1);

   logic [OUT_W*N-1:0] mux_out;
   stage_ctrl_t        ctrl_d;

   for (genvar i = 0; i < OUT_W; i++) begin : g_mux2
      assign mux_out[i*N +: N] = ctrl_in.sel[SEL_BIT] ? data_in[(i+OUT_W)*N +: N]
                                                      : data_in[i*N +: N];
   end

   always_comb begin
      ctrl_d       = ctrl_in;
      ctrl_d.sel   = ctrl_in.sel & SEL_KEEP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_out <= '0;
         data_out <= '0;
      end else if (adv) begin
         ctrl_out <= ctrl_d;
         data_out <= mux_out;
      end
   end

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - CHANNELS-way pipelined mux tree with valid/ready on both sides
// Define MUX_TREE_PIPE_COUNT_EN to add the count_clr input and xfer_count output-transfer counter.
module mux_tree_pipe
   import mux_pkg::*;
#(
   parameter int  N        = 32,
   parameter int  CHANNELS = 8,
   localparam int LEVELS   = $clog2(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CHANNELS*N-1:0] in_data,
   input  logic [LEVELS-1:0]     in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [N-1:0]          out_data,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef MUX_TREE_PIPE_COUNT_EN
   ,
   input  logic                  count_clr,
   output logic [31:0]           xfer_count
`endif
);

   // Every tree level lives in one triangular vector: level k starts at (2C - 2(C>>k))*N.
   localparam int TRI_W = (2 * CHANNELS - 1) * N;

   if (!is_pow2(CHANNELS) || LEVELS > SEL_MAX) begin : g_bad_channels
      $error("mux_tree_pipe: CHANNELS must be a power of two >= 2");
   end

   stage_ctrl_t       in_ctrl;
   stage_ctrl_t       ctrl [LEVELS];
   logic [LEVELS-1:0] adv;
   logic [TRI_W-1:0]  lvl_data;
   logic              unused_sel;

   always_comb begin
      in_ctrl       = '0;
      in_ctrl.valid = in_valid;
      in_ctrl.sel   = SEL_MAX'(in_sel);
   end

   // Ready chain runs from the consumer back to the input in one pass.
   always_comb begin
      logic chain;
      chain = out_ready;
      adv   = '0;
      for (int k = LEVELS - 1; k >= 0; k--) begin
         chain  = !ctrl[k].valid || chain;
         adv[k] = chain;
      end
   end

   assign lvl_data[CHANNELS*N-1:0] = in_data;

   for (genvar k = 0; k < LEVELS; k++) begin : g_level
      localparam int IN_W    = CHANNELS >> k;
      localparam int IN_OFF  = (2 * CHANNELS - 2 * IN_W) * N;
      localparam int OUT_OFF = IN_OFF + IN_W * N;

      stage_ctrl_t ctrl_src;

      if (k == 0) begin : g_first
         assign ctrl_src = in_ctrl;
      end else begin : g_next
         assign ctrl_src = ctrl[k-1];
      end

      mux_tree_stage #(
         .N       (N),
         .IN_W    (IN_W),
         .SEL_BIT (LEVELS - 1 - k)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .adv      (adv[k]),
         .ctrl_in  (ctrl_src),
         .data_in  (lvl_data[IN_OFF +: IN_W*N]),
         .ctrl_out (ctrl[k]),
         .data_out (lvl_data[OUT_OFF +: (IN_W/2)*N])
      );
   end

   assign in_ready   = adv[0];
   assign out_valid  = ctrl[LEVELS-1].valid;
   assign out_data   = lvl_data[TRI_W-1 -: N];
   assign unused_sel = ^ctrl[LEVELS-1].sel;

`ifdef MUX_TREE_PIPE_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_count <= '0;
      end else if (count_clr) begin
         xfer_count <= '0;
      end else if (out_valid && out_ready) begin
         xfer_count <= xfer_count + 32'd1;
      end
   end
`endif

endmodule
